ysyx_22050854_mul_issue_ctrl: RTL and testbench
===============================================

# ysyx_22050854_mul_issue_ctrl

Issue and writeback controller between the EXU decode of RISC-V M-extension multiply ops (MUL, MULH, MULHSU, MULHU, MULW) and the Booth radix-4 multiplier. It decodes funct3 into the multiplier's signedness and width controls, drives its request handshake, and captures its one-cycle result pulse into a holding register. It presents the selected, sign-corrected 64-bit result to writeback under a valid/ready handshake. A one-entry operand/result cache answers the MULH→MUL fused pair without a second multiplication. A zero-operand shortcut also bypasses the multiplier.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  an op is offered
- in_ready  out  1  controller can accept an op
- in_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other codes are illegal and never driven
- in_word  in  1  MULW; in_funct3 is 000 when set
- in_rs1, in_rs2  in  64  source operand values
- in_rd  in  5  destination register
- flush  in  1  pipeline flush; cancels the in-flight op
- mul_valid  out  1  request to multiplier
- mul_mulw  out  1  32-bit request
- mul_signed  out  2  11 s×s, 10 s×u, 00 u×u
- mul_multiplicand, mul_multiplier  out  64  rs1 and rs2, respectively
- mul_ready  in  1  multiplier idle; a request is taken when mul_valid & mul_ready
- mul_out_valid  in  1  one-cycle result pulse
- mul_result_hi, mul_result_lo  in  64  valid only during mul_out_valid
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts the result
- out_rd  out  5  destination register
- out_data  out  64  result value

## Operation
- Decode:
  - MUL and MULH: signed 11.
  - MULHSU: 10.
  - MULHU: 00.
  - MULW: mulw=1, signed 11.
  - Result select: MUL → lo; MULH/MULHSU/MULHU → hi; MULW → sign-extend lo[31:0].
- FSM states:
  - IDLE: in_ready=1. On in_valid:
    - zero shortcut (either operand is 0, using [31:0] when in_word) → DONE with data 0;
    - else cache hit → DONE with cached data;
    - else latch operands and controls → REQ.
  - REQ: mul_valid=1. If mul_ready=1 this cycle → WAIT; otherwise stay in REQ.
  - WAIT: on mul_out_valid, capture the selected result into the holding register → DONE.
  - DONE: out_valid=1, holding out_rd and out_data. When out_ready=1 → IDLE.
  - DRAIN: discard the next mul_out_valid pulse → IDLE. Cache is not updated.
- Cache:
  - Entry holds valid, rs1, rs2, signed class (2 bits), hi, lo.
  - Written when a non-word op completes from the multiplier.
  - Hit condition: in_word=0, rs1 and rs2 match, and (funct3=MUL or signed class matches).
  - MULW ops never hit and never write the cache.
  - Valid is cleared only by reset.
- Flush:
  - IDLE: no effect.
  - REQ with mul_ready=0 → IDLE.
  - REQ with mul_ready=1 → DRAIN, because the request is taken that cycle.
  - WAIT → DRAIN. If mul_out_valid arrives in the same cycle as flush → IDLE, result discarded.
  - DONE → IDLE, out_valid deasserted next cycle.
  - in_valid is ignored while flush=1.
- Reset:
  - All state returns to IDLE and cache valid=0.
  - An op in progress inside the multiplier is abandoned; the multiplier is reset by the same reset.

## Timing
- Reset values:
  - in_ready=1.
  - mul_valid=0, mul_mulw=0, mul_signed=00, mul_multiplicand=0, mul_multiplier=0.
  - out_valid=0, out_rd=0, out_data=0.
- Multiplier path:
  - Acceptance at cycle 0.
  - mul_valid is high from cycle 1.
  - out_valid is high the cycle after mul_out_valid.
- Shortcut and cache hit: out_valid at cycle 1. mul_valid is never asserted.
- mul_* outputs are registered and stable while in REQ.
- out_data and out_rd are stable while out_valid=1 and out_ready=0.
- Throughput: back-to-back hits yield one result every 2 cycles (DONE→IDLE→DONE).

## Structure
- Shared package ysyx_22050854_mul_pkg holds:
  - funct3 localparams (MUL/MULH/MULHSU/MULHU);
  - signed-class encodings 11/10/00;
  - the FSM state enum.
- One sub-module, ysyx_22050854_mul_result_cache: the entry register, write port and hit comparator, with the hit output purely combinational.

## Test plan
- MUL rs1=3, rs2=-5 → out_data 0xFFFF_FFFF_FFFF_FFF1; mul_signed=11 seen during REQ.
- MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF → out_data 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0; must miss the cache because the signed class differs.
- MULW rs1=0x7FFF_FFFF, rs2=2 → out_data 0xFFFF_FFFF_FFFF_FFFE, with mul_mulw=1.
- MULH a,b then MUL a,b (a=0x1234_5678_9ABC_DEF0, b=7):
  - second op produces out_valid at cycle 1;
  - mul_valid stays 0;
  - data 0x7F6E_5D4C_3B2A_1890.
- Flush in WAIT → no out_valid; in_ready returns 1 the cycle after the mul_out_valid pulse; cache unchanged.
- out_ready held low 5 cycles in DONE → out_data and out_rd stable; in_ready stays 0. MUL rs1=0 → result 0 at cycle 1.

Source files
------------

// File: rtl/ysyx_22050854_mul_pkg.sv
// Shared types and decode helpers for the M-extension multiply issue controller.
package ysyx_22050854_mul_pkg;

  localparam int unsigned XLEN_W = 64;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned CLS_W  = 2;
  localparam int unsigned RD_W   = 5;

  localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
  localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
  localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
  localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;

  localparam logic [CLS_W-1:0] CLS_SS = 2'b11;
  localparam logic [CLS_W-1:0] CLS_SU = 2'b10;
  localparam logic [CLS_W-1:0] CLS_UU = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN_W-1:0] rs1;
    logic [XLEN_W-1:0] rs2;
    logic [CLS_W-1:0]  sclass;
    logic [XLEN_W-1:0] hi;
    logic [XLEN_W-1:0] lo;
  } cache_entry_t;

  // Operand signedness class implied by funct3 (MUL shares the s x s class).
  function automatic logic [CLS_W-1:0] sclass_of(input logic [F3_W-1:0] funct3);
    case (funct3)
      F3_MULHSU: return CLS_SU;
      F3_MULHU:  return CLS_UU;
      default:   return CLS_SS;
    endcase
  endfunction

  // Pick the architectural result half; MULW sign-extends the low word.
  function automatic logic [XLEN_W-1:0] select_result(input logic [F3_W-1:0]   funct3,
                                                      input logic              word,
                                                      input logic [XLEN_W-1:0] hi,
                                                      input logic [XLEN_W-1:0] lo);
    if (word) begin
      return {{32{lo[31]}}, lo[31:0]};
    end else if (funct3 == F3_MUL) begin
      return lo;
    end else begin
      return hi;
    end
  endfunction

endpackage

// File: rtl/ysyx_22050854_mul_result_cache.sv
// One-entry operand/result cache; lets a MULH/MUL pair on equal operands skip the multiplier.
module ysyx_22050854_mul_result_cache
  import ysyx_22050854_mul_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [XLEN_W-1:0] wr_rs1,
  input  logic [XLEN_W-1:0] wr_rs2,
  input  logic [CLS_W-1:0]  wr_sclass,
  input  logic [XLEN_W-1:0] wr_hi,
  input  logic [XLEN_W-1:0] wr_lo,
  input  logic [XLEN_W-1:0] lk_rs1,
  input  logic [XLEN_W-1:0] lk_rs2,
  input  logic [F3_W-1:0]   lk_funct3,
  input  logic              lk_word,
  output logic              hit_c,
  output logic [XLEN_W-1:0] data_c
);

  cache_entry_t entry_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '0;
    end else if (wr_en) begin
      entry_q.valid  <= 1'b1;
      entry_q.rs1    <= wr_rs1;
      entry_q.rs2    <= wr_rs2;
      entry_q.sclass <= wr_sclass;
      entry_q.hi     <= wr_hi;
      entry_q.lo     <= wr_lo;
    end
  end

  // The low half does not depend on signedness, so MUL hits on any class.
  always_comb begin
    hit_c  = entry_q.valid && !lk_word
             && (lk_rs1 == entry_q.rs1) && (lk_rs2 == entry_q.rs2)
             && ((lk_funct3 == F3_MUL) || (sclass_of(lk_funct3) == entry_q.sclass));
    data_c = (lk_funct3 == F3_MUL) ? entry_q.lo : entry_q.hi;
  end

endmodule

// File: rtl/ysyx_22050854_mul_issue_ctrl.sv
// Issue/writeback controller between EXU decode and the radix-4 Booth multiplier,
// with zero-operand and fused-pair cache shortcuts.
module ysyx_22050854_mul_issue_ctrl
  import ysyx_22050854_mul_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            mul_valid,
  output logic            mul_mulw,
  output logic [1:0]      mul_signed,
  output logic [XLEN-1:0] mul_multiplicand,
  output logic [XLEN-1:0] mul_multiplier,
  input  logic            mul_ready,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_result_hi,
  input  logic [XLEN-1:0] mul_result_lo,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data
);

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic              load_req;
  logic              load_out;
  logic              cache_wr;
  logic              is_zero;
  logic              hit_c;
  logic [XLEN-1:0]   hit_data_c;
  logic [XLEN-1:0]   sel_result_c;
  logic [XLEN-1:0]   out_data_d;
  logic [F3_W-1:0]   funct3_q;

  ysyx_22050854_mul_result_cache u_cache (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (cache_wr),
    .wr_rs1    (mul_multiplicand),
    .wr_rs2    (mul_multiplier),
    .wr_sclass (mul_signed),
    .wr_hi     (mul_result_hi),
    .wr_lo     (mul_result_lo),
    .lk_rs1    (in_rs1),
    .lk_rs2    (in_rs2),
    .lk_funct3 (in_funct3),
    .lk_word   (in_word),
    .hit_c     (hit_c),
    .data_c    (hit_data_c)
  );

  // MULW only looks at the low words, so upper garbage must not defeat the shortcut.
  assign is_zero = in_word ? ((in_rs1[31:0] == 32'd0) || (in_rs2[31:0] == 32'd0))
                           : ((in_rs1 == '0) || (in_rs2 == '0));

  assign accept       = (state_q == ST_IDLE) && in_valid && !flush;
  assign sel_result_c = select_result(funct3_q, mul_mulw, mul_result_hi, mul_result_lo);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_req   = 1'b0;
    load_out   = 1'b0;
    cache_wr   = 1'b0;
    out_data_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_zero) begin
            state_d  = ST_DONE;
            load_out = 1'b1;
          end else if (hit_c) begin
            state_d    = ST_DONE;
            load_out   = 1'b1;
            out_data_d = hit_data_c;
          end else begin
            state_d  = ST_REQ;
            load_req = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // A flush in the same cycle the request is taken still leaves a result in flight.
        if (flush) begin
          state_d = mul_ready ? ST_DRAIN : ST_IDLE;
        end else if (mul_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = mul_out_valid ? ST_IDLE : ST_DRAIN;
        end else if (mul_out_valid) begin
          state_d    = ST_DONE;
          load_out   = 1'b1;
          out_data_d = sel_result_c;
          cache_wr   = !mul_mulw;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mul_out_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered handshake flags follow the next state; payloads load on their events.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready         <= 1'b1;
      mul_valid        <= 1'b0;
      mul_mulw         <= 1'b0;
      mul_signed       <= CLS_UU;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      funct3_q         <= F3_MUL;
      out_valid        <= 1'b0;
      out_rd           <= '0;
      out_data         <= '0;
    end else begin
      in_ready  <= (state_d == ST_IDLE);
      mul_valid <= (state_d == ST_REQ);
      out_valid <= (state_d == ST_DONE);
      if (load_req) begin
        mul_mulw         <= in_word;
        mul_signed       <= in_word ? CLS_SS : sclass_of(in_funct3);
        mul_multiplicand <= in_rs1;
        mul_multiplier   <= in_rs2;
        funct3_q         <= in_funct3;
      end
      if (accept) begin
        out_rd <= in_rd;
      end
      if (load_out) begin
        out_data <= out_data_d;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_mul_issue_ctrl.sv
// Randomized self-checking bench: behavioural multiplier responder plus an arithmetic reference model.
module tb_ysyx_22050854_mul_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_word;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [4:0]  in_rd;
  logic        flush;
  logic        mul_valid;
  logic        mul_mulw;
  logic [1:0]  mul_signed;
  logic [63:0] mul_multiplicand;
  logic [63:0] mul_multiplier;
  logic        mul_ready;
  logic        mul_out_valid = 1'b0;
  logic [63:0] mul_result_hi = 64'd0;
  logic [63:0] mul_result_lo = 64'd0;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [63:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  ysyx_22050854_mul_issue_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_funct3        (in_funct3),
    .in_word          (in_word),
    .in_rs1           (in_rs1),
    .in_rs2           (in_rs2),
    .in_rd            (in_rd),
    .flush            (flush),
    .mul_valid        (mul_valid),
    .mul_mulw         (mul_mulw),
    .mul_signed       (mul_signed),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_ready        (mul_ready),
    .mul_out_valid    (mul_out_valid),
    .mul_result_hi    (mul_result_hi),
    .mul_result_lo    (mul_result_lo),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_rd           (out_rd),
    .out_data         (out_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural multiplier: accepts a request, answers after a random latency with a one-cycle pulse.
  logic        busy = 1'b0;
  int          cnt = 0;
  int          lat_min = 1;
  int          lat_max = 4;
  logic        rdy_rand = 1'b0;
  logic        force_rdy = 1'b0;
  logic        force_nrdy = 1'b0;
  logic [63:0] ma, mb;
  logic [1:0]  ms;
  logic        mw;

  assign mul_ready = !busy && rdy_rand;

  function automatic logic [127:0] wide_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic sa, input logic sb);
    logic [127:0] ea, eb;
    ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
    eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  always @(posedge clock) begin
    mul_out_valid <= 1'b0;
    mul_result_hi <= {$urandom, $urandom};
    mul_result_lo <= {$urandom, $urandom};
    rdy_rand      <= force_rdy || (!force_nrdy && ($urandom_range(0, 3) != 0));
    if (reset) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (cnt <= 1) begin
        mul_out_valid <= 1'b1;
        busy          <= 1'b0;
        if (mw) {mul_result_hi, mul_result_lo} <= wide_mul({{32{ma[31]}}, ma[31:0]},
                                                           {{32{mb[31]}}, mb[31:0]}, 1'b1, 1'b1);
        else    {mul_result_hi, mul_result_lo} <= wide_mul(ma, mb, ms[1], ms[0]);
      end else begin
        cnt <= cnt - 1;
      end
    end else if (mul_valid && mul_ready) begin
      busy <= 1'b1;
      cnt  <= $urandom_range(lat_min, lat_max);
      ma   <= mul_multiplicand;
      mb   <= mul_multiplier;
      ms   <= mul_signed;
      mw   <= mul_mulw;
    end
  end

  // Reference model: architectural result and the expected cache contents.
  logic        ref_v = 1'b0;
  logic [63:0] ref_a, ref_b;
  logic [1:0]  ref_c;

  function automatic logic [1:0] cls_of(input logic [2:0] f3);
    if (f3 == 3'b010) return 2'b10;
    if (f3 == 3'b011) return 2'b00;
    return 2'b11;
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  p64;
    if (w) begin
      p64 = {{32{a[31]}}, a[31:0]} * {{32{b[31]}}, b[31:0]};
      return {{32{p64[31]}}, p64[31:0]};
    end
    p = wide_mul(a, b, f3 != 3'b011, (f3 == 3'b000) || (f3 == 3'b001));
    return (f3 == 3'b000) ? p[63:0] : p[127:64];
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input int stall,
                        input logic kill, output logic [63:0] got, output int lat);
    logic        fast, hit, zero, seen_mv;
    logic [63:0] exp;
    int          n;
    exp  = ref_result(f3, w, a, b);
    hit  = ref_v && !w && (a == ref_a) && (b == ref_b) && ((f3 == 3'b000) || (cls_of(f3) == ref_c));
    zero = w ? ((a[31:0] == 32'd0) || (b[31:0] == 32'd0)) : ((a == 64'd0) || (b == 64'd0));
    fast = zero || hit;
    if (!fast && !w) begin
      ref_v = 1'b1; ref_a = a; ref_b = b; ref_c = cls_of(f3);
    end
    got = 64'd0;
    lat = 0;
    wait_idle();
    in_valid = 1'b1; in_funct3 = f3; in_word = w; in_rs1 = a; in_rs2 = b; in_rd = rd;
    @(posedge clock);
    #1 in_valid = 1'b0;
    in_rs1 = {$urandom, $urandom};
    seen_mv = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1 && !fast) begin
        chk("mulv_c1", 64'(mul_valid), 64'd1);
        chk("mul_signed", 64'(mul_signed), 64'(w ? 2'b11 : cls_of(f3)));
        chk("mul_mulw", 64'(mul_mulw), 64'(w));
        chk("mul_opa", mul_multiplicand, a);
        chk("mul_opb", mul_multiplier, b);
      end
      if (mul_valid) seen_mv = 1'b1;
    end while (!out_valid && n < 80);
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("mul_used", 64'(seen_mv), 64'(!fast));
    if (fast) chk("fast_lat", 64'(n), 64'd1);
    if (!out_valid) return;
    got = out_data;
    lat = n;
    chk("out_data", out_data, exp);
    chk("out_rd", 64'(out_rd), 64'(rd));
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, exp);
      chk("hold_rd", 64'(out_rd), 64'(rd));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    if (kill) flush = 1'b1;
    else out_ready = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    chk("done_exit", 64'(out_valid), 64'd0);
    chk("idle_ready", 64'(in_ready), 64'd1);
  endtask

  // Flush while the multiplier is busy: the late pulse is swallowed and nothing is written back.
  task automatic flush_wait_test(input logic [63:0] a, input logic [63:0] b);
    logic any_out, pulse;
    int   n;
    wait_idle();
    lat_min = 3; lat_max = 3; force_rdy = 1'b1;
    @(negedge clock);
    in_valid = 1'b1; in_funct3 = 3'b011; in_word = 1'b0; in_rs1 = a; in_rs2 = b; in_rd = 5'd9;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    chk("fw_mulv", 64'(mul_valid & mul_ready), 64'd1);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    any_out = 1'b0; pulse = 1'b0; n = 0;
    while (!pulse && n < 20) begin
      @(negedge clock);
      n++;
      any_out |= out_valid;
      if (mul_out_valid) begin
        pulse = 1'b1;
        chk("fw_rdy_pulse", 64'(in_ready), 64'd0);
      end
    end
    chk("fw_pulse", 64'(pulse), 64'd1);
    @(negedge clock);
    any_out |= out_valid;
    chk("fw_no_out", 64'(any_out), 64'd0);
    chk("fw_rdy_after", 64'(in_ready), 64'd1);
    lat_min = 1; lat_max = 4; force_rdy = 1'b0;
  endtask

  // Flush while REQ is stalled by mul_ready=0: the request is withdrawn.
  task automatic flush_req_test();
    wait_idle();
    force_nrdy = 1'b1;
    @(negedge clock);
    in_valid = 1'b1; in_funct3 = 3'b001; in_word = 1'b0;
    in_rs1 = 64'h0BAD_F00D_0000_0011; in_rs2 = 64'h0000_0000_0000_0033; in_rd = 5'd4;
    @(posedge clock);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("fr_mulv_hold", 64'(mul_valid), 64'd1);
      chk("fr_opa_hold", mul_multiplicand, 64'h0BAD_F00D_0000_0011);
    end
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("fr_idle", 64'(in_ready), 64'd1);
    chk("fr_mulv_off", 64'(mul_valid), 64'd0);
    chk("fr_not_taken", 64'(busy), 64'd0);
    force_nrdy = 1'b0;
  endtask

  logic [63:0] got;
  int          lat;
  logic [63:0] pa, pb;
  logic [63:0] pool [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_funct3 = 3'b000; in_word = 1'b0;
    in_rs1 = 64'd0; in_rs2 = 64'd0; in_rd = 5'd0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mul_valid", 64'(mul_valid), 64'd0);
    chk("rst_mul_mulw", 64'(mul_mulw), 64'd0);
    chk("rst_mul_signed", 64'(mul_signed), 64'd0);
    chk("rst_opa", mul_multiplicand, 64'd0);
    chk("rst_opb", mul_multiplier, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 0, 1'b0, got, lat);
    chk("tp_mul", got, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(3'b011, 1'b0, '1, '1, 5'd2, 0, 1'b0, got, lat);
    chk("tp_mulhu", got, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'b001, 1'b0, '1, '1, 5'd3, 0, 1'b0, got, lat);
    chk("tp_mulh", got, 64'd0);
    chk("tp_mulh_miss", 64'(lat > 1), 64'd1);
    run_op(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd4, 0, 1'b0, got, lat);
    chk("tp_mulw", got, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'b001, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd7, 5'd5, 0, 1'b0, got, lat);
    run_op(3'b000, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd7, 5'd6, 0, 1'b0, got, lat);
    chk("tp_pair_data", got, 64'h7F6E_5D4C_3B2A_1890);
    chk("tp_pair_lat", 64'(lat), 64'd1);
    flush_wait_test(64'h0000_0001_0000_0003, 64'h5555);
    run_op(3'b000, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd7, 5'd7, 0, 1'b0, got, lat);
    chk("tp_cache_kept", 64'(lat), 64'd1);
    run_op(3'b011, 1'b0, 64'h0000_0001_0000_0003, 64'h5555, 5'd8, 0, 1'b0, got, lat);
    flush_req_test();
    run_op(3'b010, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 5, 1'b0, got, lat);
    run_op(3'b000, 1'b0, 64'd0, 64'hDEAD_BEEF, 5'd11, 0, 1'b0, got, lat);
    chk("tp_zero", got, 64'd0);
    run_op(3'b000, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'd9, 5'd12, 0, 1'b0, got, lat);
    run_op(3'b001, 1'b0, 64'h0123_4567, 64'hFEDC_BA98_7654_3210, 5'd13, 1, 1'b1, got, lat);

    pool[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    pool[1] = 64'h8000_0000_0000_0000;
    pool[2] = 64'h0000_0000_8000_0001;
    pool[3] = 64'd1;
    pa = 64'd5; pb = 64'd6;
    for (int k = 0; k < 80; k++) begin
      logic [2:0] f3;
      logic       w;
      f3 = 3'($urandom_range(0, 3));
      w  = (f3 == 3'b000) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 9))
          0:       pa = 64'd0;
          1, 2, 3: pa = pool[$urandom_range(0, 3)];
          default: pa = {$urandom, $urandom};
        endcase
        case ($urandom_range(0, 9))
          0:       pb = {$urandom, 32'd0};
          1, 2, 3: pb = pool[$urandom_range(0, 3)];
          default: pb = {$urandom, $urandom};
        endcase
      end
      run_op(f3, w, pa, pb, 5'($urandom_range(0, 31)), $urandom_range(0, 2),
             $urandom_range(0, 7) == 0, got, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
